// File: rtl/tape_ctrl.sv
// Brainfuck data-tape sequencer: zero-fills the 256x8 tape RAM, owns the data pointer
// and keeps a cached copy of the current cell so cell ops never need a RAM read.
module tape_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ptr,
    output logic              cell_zero,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_PTR_INC   = 3'd1;
    localparam logic [2:0] CMD_PTR_DEC   = 3'd2;
    localparam logic [2:0] CMD_ADD       = 3'd3;
    localparam logic [2:0] CMD_SUB       = 3'd4;
    localparam logic [2:0] CMD_LOAD      = 3'd5;
    localparam logic [2:0] CMD_STORE     = 3'd6;
    localparam logic [2:0] CMD_CLEAR_ALL = 3'd7;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   cache_q, cache_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                accept;
    logic                sweep_last;
    logic [ADDR_W-1:0]   ptr_inc, ptr_dec;
    logic [DATA_W-1:0]   cache_inc, cache_dec;

    assign accept     = cmd_valid && !reset && (state_q == ST_IDLE);
    assign sweep_last = (clr_cnt_q[ADDR_W-1:0] == LAST_ADDR);
    assign ptr_inc    = ptr_q + ADDR_W'(1);
    assign ptr_dec    = ptr_q - ADDR_W'(1);
    assign cache_inc  = cache_q + DATA_W'(1);
    assign cache_dec  = cache_q - DATA_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= ADDR_ZERO;
            cache_q     <= DATA_ZERO;
            clr_cnt_q   <= {(ADDR_W+1){1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DATA_ZERO;
        end else begin
            ptr_q       <= ptr_d;
            cache_q     <= cache_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_last) state_d = ST_IDLE;
                else            state_d = ST_CLEAR;
            end
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_PTR_INC, CMD_PTR_DEC: state_d = ST_RD_WAIT;
                        CMD_CLEAR_ALL:            state_d = ST_CLEAR;
                        default:                  state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: state_d = ST_IDLE;
            default:    state_d = ST_CLEAR;
        endcase
    end

    // Datapath next values: pointer, cached cell, sweep counter, LOAD response
    always_comb begin
        ptr_d       = ptr_q;
        cache_d     = cache_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                if (sweep_last) begin
                    ptr_d   = ADDR_ZERO;
                    cache_d = DATA_ZERO;
                end else begin
                    ptr_d   = ptr_q;
                    cache_d = cache_q;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_PTR_INC:   ptr_d = ptr_inc;
                        CMD_PTR_DEC:   ptr_d = ptr_dec;
                        CMD_ADD:       cache_d = cache_inc;
                        CMD_SUB:       cache_d = cache_dec;
                        CMD_STORE:     cache_d = cmd_data;
                        CMD_LOAD: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = cache_q;
                        end
                        CMD_CLEAR_ALL: clr_cnt_d = {(ADDR_W+1){1'b0}};
                        default:       ptr_d = ptr_q;
                    endcase
                end else begin
                    ptr_d = ptr_q;
                end
            end
            // The RAM read issued in the accept cycle is valid now (bypass mode)
            ST_RD_WAIT: cache_d = ram_dout;
            default:    cache_d = cache_q;
        endcase
    end

    // Output logic: handshake and RAM port, gated off while reset is held
    always_comb begin
        cmd_ready = 1'b0;
        ram_ce    = 1'b0;
        ram_wre   = 1'b0;
        ram_ad    = ptr_q;
        ram_din   = DATA_ZERO;
        if (reset) begin
            cmd_ready = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ram_ce  = 1'b1;
                    ram_wre = 1'b1;
                    ram_ad  = clr_cnt_q[ADDR_W-1:0];
                end
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_ADD: begin
                                ram_ce = 1'b1; ram_wre = 1'b1; ram_din = cache_inc;
                            end
                            CMD_SUB: begin
                                ram_ce = 1'b1; ram_wre = 1'b1; ram_din = cache_dec;
                            end
                            CMD_STORE: begin
                                ram_ce = 1'b1; ram_wre = 1'b1; ram_din = cmd_data;
                            end
                            CMD_PTR_INC: begin
                                ram_ce = 1'b1; ram_ad = ptr_inc;
                            end
                            CMD_PTR_DEC: begin
                                ram_ce = 1'b1; ram_ad = ptr_dec;
                            end
                            CMD_NOP, CMD_LOAD, CMD_CLEAR_ALL: ram_ce = 1'b0;
                            default: ram_ce = 1'b0;
                        endcase
                    end else begin
                        ram_ce = 1'b0;
                    end
                end
                ST_RD_WAIT: cmd_ready = 1'b0;
                default:    cmd_ready = 1'b0;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ptr       = ptr_q;
    assign cell_zero = reset || (cache_q == DATA_ZERO);
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

endmodule

// File: tb/tb_tape_ctrl.sv
// Self-checking bench for tape_ctrl: behavioural RAM plus a tape/pointer reference model,
// directed scenarios followed by randomized command streams.
module tb_tape_ctrl;

    localparam logic [2:0] C_NOP = 3'd0, C_INC = 3'd1, C_DEC = 3'd2, C_ADD = 3'd3,
                           C_SUB = 3'd4, C_LOAD = 3'd5, C_STORE = 3'd6, C_CLR = 3'd7;

    logic       clk, reset, cmd_valid, cmd_ready, rsp_valid, cell_zero;
    logic [2:0] cmd;
    logic [7:0] cmd_data, rsp_data, ptr, ram_ad, ram_din, ram_dout;
    logic       ram_ce, ram_wre, ram_oce, ram_reset;

    tape_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ptr(ptr), .cell_zero(cell_zero), .ram_ce(ram_ce), .ram_wre(ram_wre),
        .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, bypass read: data appears the cycle after the read edge
    logic [7:0] mem [256];
    logic       dirty_req;
    always @(posedge clk) begin
        if (dirty_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom_range(1, 255));
        end else if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout    <= mem[ram_ad];
        end
    end

    // Reference model
    logic [7:0] ref_tape [256];
    logic [7:0] ref_ptr;
    logic       exp_rsp_v;
    logic [7:0] exp_rsp_d;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cleared();
        for (int i = 0; i < 256; i++) ref_tape[i] = 8'd0;
        ref_ptr   = 8'd0;
        exp_rsp_v = 1'b0;
    endtask

    // Called just after a negedge; checks every sweep cycle, optionally asserting reset at abort_at
    task automatic sweep(input int abort_at);
        for (int k = 0; k < 256; k++) begin
            #1;
            chk("sweep_ready", cmd_ready, 1'b0);
            chk("sweep_ce", ram_ce, 1'b1);
            chk("sweep_wre", ram_wre, 1'b1);
            chk($sformatf("sweep_ad[%0d]", k), ram_ad, k);
            chk("sweep_din", ram_din, 8'd0);
            chk("sweep_rsp_valid", rsp_valid, 1'b0);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_ce", ram_ce, 1'b0);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        model_cleared();
    endtask

    task automatic do_reset(input int n, input int abort_at);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_ready", cmd_ready, 1'b0);
            chk("rst_ce", ram_ce, 1'b0);
            chk("rst_wre", ram_wre, 1'b0);
            chk("rst_cell_zero", cell_zero, 1'b1);
            chk("rst_ram_reset", ram_reset, 1'b1);
            chk("ram_oce", ram_oce, 1'b1);
            if (i > 0) begin
                chk("rst_ptr", ptr, 8'd0);
                chk("rst_rsp_valid", rsp_valid, 1'b0);
                chk("rst_rsp_data", rsp_data, 8'd0);
            end
            @(negedge clk);
        end
        reset     = 1'b0;
        exp_rsp_v = 1'b0;
        exp_rsp_d = 8'd0;
        sweep(abort_at);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        #1;
        chk("idle_ready", cmd_ready, 1'b1);
        chk("idle_ce", ram_ce, 1'b0);
        chk("idle_ptr", ptr, ref_ptr);
        chk("idle_cell_zero", cell_zero, ref_tape[ref_ptr] == 8'd0);
        chk("idle_rsp_valid", rsp_valid, exp_rsp_v);
        chk("idle_rsp_data", rsp_data, exp_rsp_d);
        exp_rsp_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        logic [7:0] cur, nv, next_ptr;
        logic       e_ce, e_wre;
        logic [7:0] e_ad;
        cur      = ref_tape[ref_ptr];
        nv       = cur;
        next_ptr = ref_ptr;
        e_ce = 1'b0; e_wre = 1'b0; e_ad = ref_ptr;
        case (c)
            C_ADD:   begin nv = cur + 8'd1; e_ce = 1'b1; e_wre = 1'b1; end
            C_SUB:   begin nv = cur - 8'd1; e_ce = 1'b1; e_wre = 1'b1; end
            C_STORE: begin nv = d;          e_ce = 1'b1; e_wre = 1'b1; end
            C_INC:   begin next_ptr = ref_ptr + 8'd1; e_ce = 1'b1; e_ad = next_ptr; end
            C_DEC:   begin next_ptr = ref_ptr - 8'd1; e_ce = 1'b1; e_ad = next_ptr; end
            default: e_ce = 1'b0;
        endcase
        cmd_valid = 1'b1; cmd = c; cmd_data = d;
        #1;
        chk("ready", cmd_ready, 1'b1);
        chk("ptr", ptr, ref_ptr);
        chk("cell_zero", cell_zero, cur == 8'd0);
        chk("rsp_valid", rsp_valid, exp_rsp_v);
        chk("rsp_data", rsp_data, exp_rsp_d);
        chk("ram_ce", ram_ce, e_ce);
        if (e_ce) begin
            chk("ram_wre", ram_wre, e_wre);
            chk("ram_ad", ram_ad, e_ad);
            if (e_wre) chk("ram_din", ram_din, nv);
        end
        exp_rsp_v = 1'b0;
        @(negedge clk);
        ref_tape[ref_ptr] = nv;
        if (c == C_LOAD) begin
            exp_rsp_v = 1'b1;
            exp_rsp_d = cur;
        end
        if (c == C_INC || c == C_DEC) begin
            ref_ptr = next_ptr;
            cmd = C_ADD;
            #1;
            chk("rdwait_ready", cmd_ready, 1'b0);
            chk("rdwait_ce", ram_ce, 1'b0);
            chk("rdwait_ptr", ptr, ref_ptr);
            chk("rdwait_rsp_valid", rsp_valid, 1'b0);
            @(negedge clk);
        end
        if (c == C_CLR) begin
            cmd_valid = 1'b0;
            sweep(-1);
        end
    endtask

    task automatic mem_check();
        for (int i = 0; i < 256; i++) chk($sformatf("tape[%0d]", i), mem[i], ref_tape[i]);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; cmd_data = 8'd0;
        exp_rsp_v = 1'b0; exp_rsp_d = 8'd0; ref_ptr = 8'd0;
        for (int i = 0; i < 256; i++) ref_tape[i] = 8'd0;
        dirty_req = 1'b1;
        @(negedge clk);
        dirty_req = 1'b0;

        // Power-on sweep
        do_reset(3, -1);
        idle();
        mem_check();

        // ADD x3 then LOAD
        issue(C_ADD, 8'd0); issue(C_ADD, 8'd0); issue(C_ADD, 8'd0);
        issue(C_LOAD, 8'd0);
        idle();
        chk("ram0_after_add", mem[0], 8'd3);

        // SUB wrap 0 -> 255, then PTR_DEC wrap 0 -> 255
        issue(C_STORE, 8'd0);
        issue(C_SUB, 8'd0);
        issue(C_LOAD, 8'd0);
        issue(C_DEC, 8'd0);
        idle();
        chk("ram0_after_sub", mem[0], 8'd255);

        // Pointer walk with cache refill from RAM
        issue(C_INC, 8'd0);
        issue(C_STORE, 8'h5A);
        issue(C_INC, 8'd0); issue(C_INC, 8'd0); issue(C_DEC, 8'd0);
        issue(C_LOAD, 8'd0);
        issue(C_DEC, 8'd0);
        issue(C_LOAD, 8'd0);
        idle();

        // Walk to 255 then wrap to 0
        for (int i = 0; i < 255; i++) issue(C_INC, 8'd0);
        issue(C_STORE, 8'hC3);
        issue(C_INC, 8'd0);
        issue(C_LOAD, 8'd0);
        idle();

        // Reset while in RD_WAIT
        issue(C_STORE, 8'h77);
        cmd_valid = 1'b1; cmd = C_INC;
        @(negedge clk);
        cmd_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rdwait_rst_ready", cmd_ready, 1'b0);
        chk("rdwait_rst_ce", ram_ce, 1'b0);
        chk("rdwait_rst_cell_zero", cell_zero, 1'b1);
        @(negedge clk);
        do_reset(2, -1);
        issue(C_LOAD, 8'd0);
        idle();
        mem_check();

        // Reset at sweep address 100, then a full restart
        dirty_req = 1'b1;
        @(negedge clk);
        dirty_req = 1'b0;
        do_reset(2, 100);
        do_reset(2, -1);
        idle();
        mem_check();

        // Randomized command stream
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 20)       idle();
            else if (r == 20) issue(C_CLR, 8'd0);
            else              issue(3'($urandom_range(0, 6)), 8'($urandom));
        end
        idle();
        mem_check();

        // CLEAR_ALL after writes
        issue(C_STORE, 8'h11); issue(C_INC, 8'd0); issue(C_STORE, 8'h22);
        issue(C_CLR, 8'd0);
        idle();
        mem_check();
        issue(C_LOAD, 8'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tape_ctrl.md
# tape_ctrl

Sequencer for the Brainfuck data tape held in the 256×8 single-port block RAM (`Gowin_SP`). It zero-fills the tape after reset and owns the data pointer. It keeps a coherent copy of the current cell, so `+`, `-`, `.`, `,`, `[` and `]` complete without a RAM read. It sits between the CPU execute stage (valid/ready command port) and the RAM macro, and is the RAM's only master.

## Interface
- `ADDR_W`, 8, tape address width; tape length 2^ADDR_W cells.
- `DATA_W`, 8, cell width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on `cmd_valid & cmd_ready`.
- `cmd` in 3: 0 NOP, 1 PTR_INC, 2 PTR_DEC, 3 ADD, 4 SUB, 5 LOAD, 6 STORE, 7 CLEAR_ALL.
- `cmd_data` in DATA_W: value for STORE.
- `rsp_valid` out 1: one-cycle pulse carrying the LOAD result.
- `rsp_data` out DATA_W: LOAD result; holds its value between pulses.
- `ptr` out ADDR_W: current data pointer.
- `cell_zero` out 1: current cell == 0; meaningful only while `cmd_ready`=1.
- `ram_ce`, `ram_wre` out 1: RAM clock enable and write enable.
- `ram_oce` out 1: constant 1.
- `ram_reset` out 1: equals `reset`.
- `ram_ad` out ADDR_W: RAM address.
- `ram_din` out DATA_W: RAM write data.
- `ram_dout` in DATA_W: RAM read data. The RAM runs in bypass read mode, so data is valid in the cycle after the read edge.

## Operation
- Registers: `state` ∈ {CLEAR, IDLE, RD_WAIT}, `ptr`, `cache` (copy of the cell at `ptr`), `clr_cnt` (ADDR_W+1 bits).
- Reset values: state=CLEAR, ptr=0, cache=0, clr_cnt=0, rsp_valid=0, rsp_data=0.
- While `reset`=1, `ram_ce`=`ram_wre`=0 and `cmd_ready`=0; `cell_zero`=1.
- RAM ports are combinational from state and the accepted command.
- CLEAR state:
  - Each cycle: ram_ce=1, ram_wre=1, ram_ad=clr_cnt[ADDR_W-1:0], ram_din=0; clr_cnt increments.
  - After the write to address 2^ADDR_W−1, go to IDLE with ptr=0, cache=0.
  - cmd_ready=0 throughout.
- IDLE state: cmd_ready=1. On acceptance:
  - NOP: no effect.
  - ADD / SUB: write cache±1 (mod 2^DATA_W, wraps 255→0 and 0→255) to ram_ad=ptr in the same cycle; cache updates at the edge; stay in IDLE.
  - STORE: write cmd_data to ptr; cache←cmd_data; stay in IDLE.
  - LOAD: next cycle rsp_valid=1 and rsp_data=cache. No RAM access. Stay in IDLE.
  - PTR_INC / PTR_DEC:
    - In the accept cycle, issue a read: ram_ce=1, ram_wre=0, ram_ad=ptr±1 (mod 2^ADDR_W, wraps 255→0 and 0→255).
    - ptr updates at the edge; go to RD_WAIT.
  - CLEAR_ALL: clr_cnt←0; go to CLEAR (ptr and cache are zeroed at sweep end).
- RD_WAIT state: cmd_ready=0, ram_ce=0; cache←ram_dout; go to IDLE.
- `cell_zero` = (cache == 0), combinational.
- `reset` asserted in any state, including mid-sweep or in RD_WAIT, restarts the full sweep from address 0 on the next cycle. Any pending rsp_valid is dropped.
- Back-to-back ADD/SUB/STORE/LOAD run at one per cycle, each seeing the previous result through cache.

## Timing
- Sweep: with the first post-reset cycle as cycle 1, address k is written in cycle k+1. `cmd_ready` first rises in cycle 2^ADDR_W+1 (257 at default).
- ADD, SUB, STORE, NOP: 1 cycle; the next command can be accepted in the next cycle.
- LOAD: rsp_valid in the cycle after acceptance; 1 cycle/command.
- PTR_INC / PTR_DEC: 2 cycles (accept, RD_WAIT). cmd_ready=0 in the second; `ptr` shows the new value from the second cycle on.
- CLEAR_ALL: 2^ADDR_W cycles with cmd_ready=0, then IDLE.
- `rsp_valid` is never asserted while state=CLEAR.

## Test plan
- Reset for 3 cycles, release → 256 writes of 0 to addresses 0..255 in order; cmd_ready rises in cycle 257; ptr=0, cell_zero=1.
- ADD×3, LOAD → RAM[0] written 1, 2, 3 on consecutive cycles; rsp_valid pulse with rsp_data=3; cell_zero=0.
- SUB at ptr=0 with cell=0 → RAM[0]=255 and cache=255. Then PTR_DEC → ptr=255, cmd_ready low for exactly 1 cycle, cache=RAM[255]=0.
- STORE 0x5A, PTR_INC, PTR_INC, PTR_DEC, LOAD → ptr sequence 1, 2, 1, 0x5A was stored at address 0, and the final LOAD at address 1 returns 0. Then PTR_DEC, LOAD → rsp_data=0x5A.
- PTR_INC issued to reach ptr=255, then PTR_INC → ptr=0 and cache=RAM[0] (wrap-around).
- Assert reset during RD_WAIT and separately at sweep address 100 → no read capture occurs and the sweep restarts at address 0. CLEAR_ALL after writes → all cells read back 0, ptr=0.
